// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM/error encodings and access classification for the data memory responder.
package data_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_ALIGN = 2'd1, ERR_RANGE = 2'd2, ERR_CONFLICT = 2'd3} err_cause_e;
  function automatic err_cause_e classify(input logic [31:0] addr, input logic rd, input logic wr,
                                          input int unsigned depth);
    return (rd && wr) ? ERR_CONFLICT : (addr[1:0] != 2'b00) ? ERR_ALIGN :
           ((addr >> 2) >= depth) ? ERR_RANGE : ERR_NONE;
  endfunction
endpackage

// File: rtl/data_mem_responder_mem_array_1rw.sv
// mem_array_1rw: single-port synchronous 32-bit RAM with write enable and registered read.
module mem_array_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  always_ff @(posedge clk)
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  // The read register holds its value between reads so the load result stays visible.
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word data memory with request/ready handshake, wait states and access error flagging.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  state_e state_q, state_d;
  err_cause_e cause_q, cur_cause;
  logic [3:0] cnt_q, cnt_d;
  logic op_rd_q, op_wr_q, zero_q, zero_d;
  logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, ram_rdata;
  logic cur_rd, cur_wr, accept, commit, ok;
  // With zero latency the commit edge is the accept edge, so IDLE works from the live inputs.
  always_comb begin
    cur_rd = (state_q == IDLE) ? memRead : op_rd_q;
    cur_wr = (state_q == IDLE) ? memWrite : op_wr_q;
    cur_addr = (state_q == IDLE) ? address : addr_q;
    cur_wdata = (state_q == IDLE) ? writeData : wdata_q;
    cur_cause = classify(cur_addr, cur_rd, cur_wr, DEPTH);
    ok = (cur_cause == ERR_NONE);
    accept = (state_q == IDLE) && (memRead || memWrite);
    commit = (state_d == RESP) && (state_q != RESP);
    zero_d = !ok ? 1'b1 : cur_rd ? 1'b0 : zero_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (LATENCY == 0) ? RESP : WAIT;
        cnt_d = CNT_INIT;
      end
      WAIT: begin
        state_d = (cnt_q == 4'd0) ? RESP : WAIT;
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cause_q <= ERR_NONE;
      zero_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        op_rd_q <= memRead;
        op_wr_q <= memWrite;
        addr_q <= address;
        wdata_q <= writeData;
        cause_q <= cur_cause;
      end
      if (commit) zero_q <= zero_d;
    end
  mem_array_1rw #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst_ni(rst),
    .en_i(commit && ok),
    .we_i(cur_wr),
    .addr_i(cur_addr[AW+1:2]),
    .wdata_i(cur_wdata),
    .rdata_o(ram_rdata)
  );
  always_comb begin
    ready = (state_q == RESP);
    busy = (state_q != IDLE);
    err = ready && (cause_q != ERR_NONE);
    readData = zero_q ? '0 : ram_rdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench driving a LATENCY=2 and a LATENCY=0 responder against a word-array model.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT [2] = '{2, 0};
  typedef struct {logic e; logic [31:0] d; bit c; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rstn [2];
  logic rd [2], wr [2], rdy [2], er [2], bz [2];
  logic [31:0] a [2], wd [2], rdata [2];
  exp_t q0 [$], q1 [$];
  logic [31:0] mem [int];
  bit prev [2] = '{0, 0};
  int cyc = 0, n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u0 (
    .clk(clk), .rst(rstn[0]), .memRead(rd[0]), .memWrite(wr[0]), .address(a[0]),
    .writeData(wd[0]), .readData(rdata[0]), .ready(rdy[0]), .err(er[0]), .busy(bz[0]));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u1 (
    .clk(clk), .rst(rstn[1]), .memRead(rd[1]), .memWrite(wr[1]), .address(a[1]),
    .writeData(wd[1]), .readData(rdata[1]), .ready(rdy[1]), .err(er[1]), .busy(bz[1]));
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", nm, k, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (prev[k]) begin
        chk("ready_pulse", k, {31'b0, rdy[k]}, 32'd0);
        chk("busy_after_resp", k, {31'b0, bz[k]}, 32'd0);
      end
      prev[k] = rdy[k];
      if (rdy[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready dut%0d at cycle %0d", k, cyc);
        end else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("err", k, {31'b0, er[k]}, {31'b0, e.e});
          if (e.c) chk("readData", k, rdata[k], e.d);
          chk("ready_cycle", k, cyc, e.cyc);
        end
      end
    end
  end
  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      a[k] = '0;
      wd[k] = '0;
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((bz[0] || bz[1]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy stuck at cycle %0d", cyc);
    end
  endtask
  task automatic issue(input bit [1:0] m, input logic r, input logic w, input logic [31:0] adr,
                       input logic [31:0] dat, input bit push);
    exp_t x;
    int idx = int'(adr >> 2);
    wait_idle();
    x.e = (r && w) || (adr[1:0] != 2'b00) || (adr >= DEPTH * 4);
    x.c = x.e || (r && mem.exists(idx));
    x.d = (x.e || !mem.exists(idx)) ? 32'd0 : mem[idx];
    for (int k = 0; k < 2; k++)
      if (m[k]) begin
        rd[k] = r;
        wr[k] = w;
        a[k] = adr;
        wd[k] = dat;
        x.cyc = cyc + 1 + LAT[k];
        if (push && k == 0) q0.push_back(x);
        if (push && k == 1) q1.push_back(x);
      end
    if (push && !x.e && w) mem[idx] = dat;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask
  task automatic chk_reset(input int k);
    chk("rst_readData", k, rdata[k], 32'd0);
    chk("rst_ready", k, {31'b0, rdy[k]}, 32'd0);
    chk("rst_err", k, {31'b0, er[k]}, 32'd0);
    chk("rst_busy", k, {31'b0, bz[k]}, 32'd0);
  endtask
  initial begin
    int t;
    logic [31:0] adr;
    logic r, w;
    clear_inputs();
    rstn[0] = 1'b0;
    rstn[1] = 1'b0;
    #12;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    for (int i = 0; i < 32; i++) issue(2'b11, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b1);
    issue(2'b11, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
    issue(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    issue(2'b11, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b1);
    issue(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    issue(2'b11, 1'b0, 1'b1, 32'h42, 32'h11111111, 1'b1);
    issue(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    issue(2'b11, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1);
    issue(2'b11, 1'b0, 1'b1, 32'hFFC, 32'h600DF00D, 1'b1);
    issue(2'b11, 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b1);
    issue(2'b11, 1'b1, 1'b1, 32'h40, 32'h22222222, 1'b1);
    issue(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    // A write launched while both responders are still busy must be dropped.
    issue(2'b11, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wr[k] = 1'b1;
      a[k] = 32'h44;
    end
    @(negedge clk);
    clear_inputs();
    issue(2'b11, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
    // Held read on the zero-latency responder: accepts on every second edge.
    wait_idle();
    rd[1] = 1'b1;
    for (int j = 0; j < 3; j++) q1.push_back('{1'b0, mem[0], 1'b1, cyc + 1 + 2 * j});
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear_inputs();
    // Reset during the wait states abandons the write.
    issue(2'b11, 1'b0, 1'b1, 32'h48, 32'h0BADF00D, 1'b1);
    issue(2'b01, 1'b0, 1'b1, 32'h48, 32'hCAFEF00D, 1'b0);
    rstn[0] = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    rstn[0] = 1'b1;
    issue(2'b01, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(0, 9);
      r = 1'(($urandom_range(0, 1)));
      w = !r;
      adr = 32'($urandom_range(0, 31)) << 2;
      if (t == 0) adr = adr | 32'($urandom_range(1, 3));
      if (t == 1) adr = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      if (t == 2) adr = {1'b1, 31'($urandom)} & ~32'h3;
      if (t == 3) begin
        r = 1'b1;
        w = 1'b1;
      end
      issue(2'b11, r, w, adr, $urandom, 1'b1);
    end
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d and %0d responses missing", q0.size(), q1.size());
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
